// File: rtl/onchip_ram_ctrl_if.sv
// onchip_ram_ctrl_if: sdram_* bus between master and on-chip RAM.
// master drives stb/we/sel/adr/out; slave drives dat/ack/ready.
interface onchip_ram_ctrl_if;
  logic        sdram_stb;
  logic        sdram_we;
  logic [1:0]  sdram_sel;
  logic [21:1] sdram_adr;
  logic [15:0] sdram_out;
  logic [15:0] sdram_dat;
  logic        sdram_ack;
  logic        sdram_ready;

  modport master (
    output sdram_stb, sdram_we, sdram_sel,
    output sdram_adr, sdram_out,
    input  sdram_dat, sdram_ack, sdram_ready
  );

  modport slave (
    input  sdram_stb, sdram_we, sdram_sel,
    input  sdram_adr, sdram_out,
    output sdram_dat, sdram_ack, sdram_ready
  );
endinterface

// File: rtl/onchip_ram_ctrl.sv
// onchip_ram_ctrl: 2**AW x 16 on-chip RAM with wait-state bus cycles.
// Ports: clk_p, sdram_reset (sync, high), bus (slave modport).
module onchip_ram_ctrl #(
  parameter int          AW          = 15,
  parameter int          WAIT_STATES = 1,
  parameter bit          INIT_CLEAR  = 1'b1,
  parameter logic [15:0] INIT_VALUE  = 16'o0
) (
  input  logic              clk_p,
  input  logic              sdram_reset,
  onchip_ram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_WAIT, S_ACK
  } state_t;

  localparam int          DEPTH = 1 << AW;
  localparam logic [3:0]  WS_LD = 4'(WAIT_STATES - 1);
  localparam logic [AW-1:0] LAST = '1;
  localparam state_t      RST_ST =
    INIT_CLEAR ? S_INIT : S_IDLE;

  logic [15:0]   mem [DEPTH];
  state_t        state, state_n;
  logic [3:0]    wcnt;
  logic [AW-1:0] clr_cnt;
  logic          ack_r;
  logic          ready_r;
  logic [15:0]   dat_r;

  logic          stb, we, in_range, rd_en;
  logic [AW-1:0] idx;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_wa;
  logic [15:0]   mem_wd;

  assign stb      = bus.sdram_stb;
  assign we       = bus.sdram_we;
  assign idx      = bus.sdram_adr[AW:1];
  assign in_range = (bus.sdram_adr[21:AW+1] == '0);

  always_ff @(posedge clk_p) begin
    if (sdram_reset) state <= RST_ST;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT: if (clr_cnt == LAST) state_n = S_IDLE;
      S_IDLE: if (stb) state_n = S_WAIT;
      S_WAIT: begin
        if (!stb)             state_n = S_IDLE;
        else if (wcnt == '0)  state_n = S_ACK;
      end
      S_ACK:  if (!stb) state_n = S_IDLE;
      default: state_n = RST_ST;
    endcase
  end

  // The only RAM access of a cycle happens on its first edge;
  // later edges of WAIT/ACK never touch memory.
  always_comb begin
    mem_be = 2'b00;
    mem_wa = idx;
    mem_wd = bus.sdram_out;
    rd_en  = 1'b0;
    unique case (state)
      S_INIT: begin
        mem_be = 2'b11;
        mem_wa = clr_cnt;
        mem_wd = INIT_VALUE;
      end
      S_IDLE: begin
        if (stb && we && in_range) mem_be = bus.sdram_sel;
        if (stb && !we)            rd_en  = 1'b1;
      end
      default: ;
    endcase
    if (sdram_reset) begin
      mem_be = 2'b00;
      rd_en  = 1'b0;
    end
  end

  always_ff @(posedge clk_p) begin
    if (mem_be[0]) mem[mem_wa][7:0]  <= mem_wd[7:0];
    if (mem_be[1]) mem[mem_wa][15:8] <= mem_wd[15:8];
  end

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      ack_r   <= 1'b0;
      wcnt    <= '0;
      clr_cnt <= '0;
      ready_r <= !INIT_CLEAR;
      dat_r   <= '0;
    end else begin
      if (state == S_INIT) begin
        if (clr_cnt == LAST) ready_r <= 1'b1;
        else                 clr_cnt <= clr_cnt + AW'(1);
      end
      if (state == S_IDLE && stb)
        wcnt <= WS_LD;
      else if (state == S_WAIT && stb && wcnt != '0)
        wcnt <= wcnt - 4'd1;
      if (state == S_WAIT && stb && wcnt == '0)
        ack_r <= 1'b1;
      else if (state == S_ACK && !stb)
        ack_r <= 1'b0;
      // Out-of-range reads alias into RAM; force them to zero.
      if (rd_en) dat_r <= in_range ? mem[idx] : '0;
    end
  end

  // Combinational so the master sees ack drop with its own stb.
  assign bus.sdram_ack   = stb & ack_r;
  assign bus.sdram_dat   = dat_r;
  assign bus.sdram_ready = ready_r;

endmodule

// File: tb/tb_onchip_ram_ctrl.sv
// tb_onchip_ram_ctrl: scoreboard bench for onchip_ram_ctrl.
// u_dut: AW=4/WS=3/clear; u_leg: AW=15/WS=1/no clear.
module tb_onchip_ram_ctrl;

  localparam int          AW = 4;
  localparam int          WS = 3;
  localparam logic [15:0] IV = 16'o177777;

  typedef struct {
    bit          is_rd;
    logic [15:0] dat;
    int          ack_cyc;
  } exp_t;

  logic clk_p = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [15:0] model [1 << AW];
  exp_t        exp_q [$];
  exp_t        m_e;
  logic        ack_prev = 1'b0;

  always #5 clk_p = ~clk_p;
  always @(posedge clk_p) cyc <= cyc + 1;

  onchip_ram_ctrl_if bus_a ();
  onchip_ram_ctrl_if bus_b ();

  onchip_ram_ctrl #(
    .AW(AW), .WAIT_STATES(WS),
    .INIT_CLEAR(1'b1), .INIT_VALUE(IV)
  ) u_dut (
    .clk_p(clk_p), .sdram_reset(rst_a), .bus(bus_a)
  );

  onchip_ram_ctrl #(
    .AW(15), .WAIT_STATES(1),
    .INIT_CLEAR(1'b0), .INIT_VALUE(16'o0)
  ) u_leg (
    .clk_p(clk_p), .sdram_reset(rst_b), .bus(bus_b)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < (1 << AW); i++) model[i] = IV;
  endtask

  // Monitor: away from both edges used by the drivers.
  always begin
    @(posedge clk_p);
    #2;
    if (bus_a.sdram_ack && !ack_prev) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d, want none",
                 cyc);
      end else begin
        m_e = exp_q.pop_front();
        check("ack_latency", cyc, m_e.ack_cyc);
        if (m_e.is_rd) check("read_data", bus_a.sdram_dat, m_e.dat);
      end
    end
    ack_prev = bus_a.sdram_ack;
  end

  task automatic a_issue(input logic we, input logic [1:0] sel,
                         input logic [21:1] adr,
                         input logic [15:0] d, input bit want_ack);
    exp_t       e;
    logic       in_r;
    logic [3:0] ix;
    in_r = (adr[21:AW+1] == '0);
    ix   = adr[AW:1];
    bus_a.sdram_we  = we;
    bus_a.sdram_sel = sel;
    bus_a.sdram_adr = adr;
    bus_a.sdram_out = d;
    bus_a.sdram_stb = 1'b1;
    if (we && in_r) begin
      if (sel[0]) model[ix][7:0]  = d[7:0];
      if (sel[1]) model[ix][15:8] = d[15:8];
    end
    if (want_ack) begin
      e.is_rd   = !we;
      e.dat     = in_r ? model[ix] : 16'h0;
      e.ack_cyc = cyc + 1 + WS;
      exp_q.push_back(e);
    end
  endtask

  task automatic a_wait_ack();
    int n = 0;
    while (!bus_a.sdram_ack && n < 60) begin
      @(negedge clk_p);
      n++;
    end
    if (!bus_a.sdram_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, want ack", n);
    end
  endtask

  task automatic a_finish(input int hold);
    bit ok = 1'b1;
    a_wait_ack();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_p);
      if (!bus_a.sdram_ack) ok = 1'b0;
    end
    if (hold > 0) check("ack_held", ok, 1);
    bus_a.sdram_stb = 1'b0;
    #1;
    check("ack_drop_with_stb", bus_a.sdram_ack, 0);
    @(negedge clk_p);
  endtask

  task automatic a_abort(input logic we, input logic [1:0] sel,
                         input logic [21:1] adr,
                         input logic [15:0] d, input int k);
    a_issue(we, sel, adr, d, 1'b0);
    repeat (k) @(negedge clk_p);
    bus_a.sdram_stb = 1'b0;
    @(negedge clk_p);
  endtask

  task automatic b_txn(input logic we, input logic [1:0] sel,
                       input logic [21:1] adr, input logic [15:0] d,
                       output logic [15:0] rd, output int lat);
    bus_b.sdram_we  = we;
    bus_b.sdram_sel = sel;
    bus_b.sdram_adr = adr;
    bus_b.sdram_out = d;
    bus_b.sdram_stb = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_p);
      lat++;
    end while (!bus_b.sdram_ack && lat < 20);
    rd = bus_b.sdram_dat;
    bus_b.sdram_stb = 1'b0;
    @(negedge clk_p);
  endtask

  task automatic b_abort(input logic we, input logic [21:1] adr,
                         input logic [15:0] d);
    logic seen = 1'b0;
    bus_b.sdram_we  = we;
    bus_b.sdram_sel = 2'b11;
    bus_b.sdram_adr = adr;
    bus_b.sdram_out = d;
    bus_b.sdram_stb = 1'b1;
    @(negedge clk_p);
    seen |= bus_b.sdram_ack;
    bus_b.sdram_stb = 1'b0;
    repeat (3) begin
      @(negedge clk_p);
      seen |= bus_b.sdram_ack;
    end
    check("leg_abort_noack", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic [21:1] adr;
    int          lat;
    int          z;
    bus_a.sdram_stb = 1'b0;
    bus_a.sdram_we  = 1'b0;
    bus_a.sdram_sel = 2'b00;
    bus_a.sdram_adr = '0;
    bus_a.sdram_out = '0;
    bus_b.sdram_stb = 1'b0;
    bus_b.sdram_we  = 1'b0;
    bus_b.sdram_sel = 2'b00;
    bus_b.sdram_adr = '0;
    bus_b.sdram_out = '0;
    repeat (2) @(negedge clk_p);

    check("rst_ready", bus_a.sdram_ready, 0);
    check("rst_dat", bus_a.sdram_dat, 0);
    check("leg_rst_ready", bus_b.sdram_ready, 1);
    check("leg_rst_dat", bus_b.sdram_dat, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    model_fill();
    z = 0;
    while (!bus_a.sdram_ready && z < 100) begin
      z++;
      @(negedge clk_p);
    end
    check("ready_low_cycles", z, 16);

    a_issue(1'b0, 2'b00, 21'd5, 16'h0, 1'b1);
    a_finish(0);

    a_issue(1'b1, 2'b11, 21'o100, 16'h5555, 1'b1);
    a_finish(0);
    a_issue(1'b0, 2'b00, 21'o100, 16'h0, 1'b1);
    a_finish(0);
    a_issue(1'b0, 2'b00, 21'd0, 16'h0, 1'b1);
    a_finish(0);

    a_issue(1'b0, 2'b00, 21'd2, 16'h0, 1'b1);
    a_finish(6);

    a_issue(1'b1, 2'b11, 21'd8, 16'h1234, 1'b1);
    a_finish(0);
    a_issue(1'b1, 2'b10, 21'd8, 16'hAB00, 1'b1);
    a_finish(1);
    a_issue(1'b0, 2'b00, 21'd8, 16'h0, 1'b1);
    a_finish(0);
    a_issue(1'b1, 2'b00, 21'd8, 16'hFFFF, 1'b1);
    a_finish(0);
    a_issue(1'b0, 2'b00, 21'd8, 16'h0, 1'b1);
    a_finish(2);

    a_abort(1'b0, 2'b00, 21'd8, 16'h0, 1);
    a_abort(1'b1, 2'b11, 21'd9, 16'h4242, 2);
    a_issue(1'b0, 2'b00, 21'd9, 16'h0, 1'b1);
    a_finish(0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0)
        adr = {17'($urandom_range(1, 131071)),
               4'($urandom_range(0, 15))};
      else
        adr = 21'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)
        a_abort(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                adr, 16'($urandom), $urandom_range(1, WS));
      else begin
        a_issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                adr, 16'($urandom), 1'b1);
        a_finish($urandom_range(0, 3));
      end
    end

    a_issue(1'b1, 2'b11, 21'd3, 16'h1357, 1'b1);
    a_finish(0);
    a_issue(1'b0, 2'b00, 21'd7, 16'h0, 1'b1);
    a_wait_ack();
    rst_a = 1'b1;
    bus_a.sdram_adr = 21'd3;
    @(negedge clk_p);
    check("ack_after_rst", bus_a.sdram_ack, 0);
    check("dat_after_rst", bus_a.sdram_dat, 0);
    check("ready_after_rst", bus_a.sdram_ready, 0);
    rst_a = 1'b0;
    model_fill();
    m_e.is_rd   = 1'b1;
    m_e.dat     = model[3];
    m_e.ack_cyc = cyc + 17 + WS;
    exp_q.push_back(m_e);
    a_finish(0);

    b_txn(1'b1, 2'b11, 21'o20, 16'h1234, rd, lat);
    check("leg_wr_latency", lat, 2);
    b_txn(1'b0, 2'b00, 21'o20, 16'h0, rd, lat);
    check("leg_rd_latency", lat, 2);
    check("leg_rd_1234", rd, 16'h1234);
    b_txn(1'b1, 2'b10, 21'o20, 16'hAB00, rd, lat);
    b_txn(1'b0, 2'b00, 21'o20, 16'h0, rd, lat);
    check("leg_rd_ab34", rd, 16'hAB34);
    b_txn(1'b1, 2'b00, 21'o20, 16'hFFFF, rd, lat);
    b_txn(1'b0, 2'b00, 21'o20, 16'h0, rd, lat);
    check("leg_rd_sel00", rd, 16'hAB34);
    b_abort(1'b0, 21'o20, 16'h0);
    b_abort(1'b1, 21'o21, 16'h4242);
    b_txn(1'b0, 2'b00, 21'o21, 16'h0, rd, lat);
    check("leg_abort_wr_kept", rd, 16'h4242);

    repeat (4) @(negedge clk_p);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
